// File: rtl/prog_clk_divider.sv
// Programmable clock divider: registered 50%-ish divided clock plus period tick,
// with a valid/ready divisor port whose updates take effect only on period boundaries.
module prog_clk_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_value,
  output logic             div_ready,
  output logic             div_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] pend_div;
  logic [WIDTH-1:0] phase_nxt;
  logic [WIDTH-1:0] div_eff;
  logic             xfer;
  logic             legal;
  logic             wrap;
  logic             pend_load;

  // ceil(n/2) without widening: n>>1 plus the odd bit never exceeds 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] half_up(input logic [WIDTH-1:0] n);
    return (n >> 1) + {{(WIDTH-1){1'b0}}, n[0]};
  endfunction

  assign div_ready = (state != PEND);
  assign xfer      = div_valid & div_ready;
  assign legal     = xfer & (div_value > ONE);
  assign wrap      = (phase == cur_div - ONE);
  assign phase_nxt = wrap ? '0 : phase + ONE;
  assign pend_load = (state == PEND) & wrap;
  // divisor governing the cycle being entered, so a reload starts cleanly
  assign div_eff   = pend_load ? pend_div : cur_div;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      phase    <= '0;
      cur_div  <= DEF_DIV;
      pend_div <= DEF_DIV;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_err <= xfer & ~legal;
      case (state)
        IDLE: begin
          phase <= '0;
          if (legal) cur_div <= div_value;
          if (en) begin
            state   <= RUN;
            clk_out <= 1'b1;
            tick    <= 1'b1;
          end else begin
            clk_out <= 1'b0;
            tick    <= 1'b0;
          end
        end
        default: begin
          if (!en) begin
            // abort mid-period; a waiting divisor still lands
            state   <= IDLE;
            phase   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            if (state == PEND)  cur_div <= pend_div;
            else if (legal)     cur_div <= div_value;
          end else begin
            phase   <= phase_nxt;
            tick    <= (phase_nxt == '0);
            clk_out <= (phase_nxt < half_up(div_eff));
            if (pend_load) begin
              cur_div <= pend_div;
              state   <= RUN;
            end else if (legal) begin
              pend_div <= div_value;
              state    <= PEND;
            end
          end
        end
      endcase
    end
  end

endmodule
